dcache_assoc: RTL and testbench

- Parametrised set-associative, multi-word-line successor to the core's direct-mapped write-through data cache.
- Sits between the load/store unit and the memory bus, using the same request/response handshake on both sides.
- Adds configurable ways and line length, per-set round-robin replacement, byte-strobe writes, burst line fill and a registered response path.

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_tag_array.sv | 75 +++++++
 rtl/dcache_assoc.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types and helpers for the set-associative data cache.
//               The FSM state type, the word type and the byte-strobe merge
//               function live here.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    FILL_GAP = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } dcache_state_t;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic word_t merge_bytes(input word_t old_word,
                                        input word_t new_word,
                                        input logic [3:0] strb);
    word_t result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_tag_array
// Description : Per-way tag and valid storage for the associative data cache.
//               Produces a combinational hit indication, the encoded hit way
//               and the victim way for the looked-up set, and keeps one
//               round-robin replacement pointer per set.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SET_DEPTH = 32,
  parameter int IDX_W     = 5,
  parameter int TAG_BITS  = 21,
  parameter int WAY_W     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    lookup_idx,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                hit,
  output logic [WAY_W-1:0]    hit_way,
  output logic [WAY_W-1:0]    victim_way,
  input  logic                fill_en,
  input  logic [IDX_W-1:0]    fill_idx,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [TAG_BITS-1:0] fill_tag
);

  logic [SET_DEPTH-1:0] r_valid [WAYS];
  logic [TAG_BITS-1:0]  r_tag   [WAYS][SET_DEPTH];
  logic [WAY_W-1:0]     r_ptr   [SET_DEPTH];

  logic [WAYS-1:0] w_hit_vec;
  logic [WAYS-1:0] w_inv_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign w_hit_vec[w] = r_valid[w][lookup_idx] &&
                          (r_tag[w][lookup_idx] == lookup_tag);
    assign w_inv_vec[w] = ~r_valid[w][lookup_idx];
  end

  // Encode hit way and pick victim: lowest invalid way, else the set pointer.
  always_comb begin
    hit        = |w_hit_vec;
    hit_way    = '0;
    victim_way = r_ptr[lookup_idx];
    // Descending scan so the lowest-numbered matching way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) hit_way    = WAY_W'(w);
      if (w_inv_vec[w]) victim_way = WAY_W'(w);
    end
  end

  // Valid bits and replacement pointers; a completed fill marks the line
  // valid and always advances the pointer, even into a previously invalid way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      for (int s = 0; s < SET_DEPTH; s++) r_ptr[s] <= '0;
    end else if (fill_en) begin
      r_valid[fill_way][fill_idx] <= 1'b1;
      r_ptr[fill_idx]             <= (WAYS == 1) ? '0 : r_ptr[fill_idx] + 1'b1;
    end
  end

  // Tag storage needs no reset: a tag is only consulted behind its valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) r_tag[fill_way][fill_idx] <= fill_tag;
  end

endmodule
`default_nettype wire

// File: rtl/dcache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : dcache_assoc
// Description : Set-associative, multi-word-line write-through data cache
//               between the load/store unit and the memory bus. Read misses
//               burst-fill the whole line one beat at a time; stores are
//               written through, updating the cache only on a hit.
//               Optional macro DCACHE_STATS_EN adds hit_count / miss_count
//               outputs counting read hits and read misses.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic        response,
  output logic [31:0] read_data,
  output logic        memory_read_request,
  output logic        memory_write_request,
  input  logic        memory_response,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_write_data,
  output logic [3:0]  memory_write_strobe,
  input  logic [31:0] memory_read_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS     = CACHE_SIZE / (4 * LINE_WORDS * WAYS);
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
  // Field widths padded to at least one bit; padded bits are always zero.
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DATA_AW  = WAY_W + IDX_W + OFF_W;
  localparam word_t C_LINE_MASK = ~word_t'(4 * LINE_WORDS - 1);

  function automatic logic [OFF_W-1:0] off_of(input word_t a);
    word_t s;
    s = (a >> 2) & word_t'(LINE_WORDS - 1);
    return s[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input word_t a);
    word_t s;
    s = (a >> (2 + OFF_BITS)) & word_t'(SETS - 1);
    return s[IDX_W-1:0];
  endfunction

  dcache_state_t r_state, w_next_state;

  // Request fields are captured at acceptance so the fill and bus write do
  // not depend on the requester keeping addr/data stable.
  word_t            r_addr;
  word_t            r_wdata;
  logic [3:0]       r_wstrb;
  logic [WAY_W-1:0] r_victim;
  logic [OFF_W-1:0] r_beat;
  word_t            r_read_data;
  word_t            r_data [2**DATA_AW];

  logic [OFF_W-1:0]    w_off, w_fill_off;
  logic [IDX_W-1:0]    w_idx, w_fill_idx;
  logic [TAG_BITS-1:0] w_tag, w_fill_tag;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way, w_victim_way;
  logic [DATA_AW-1:0]  w_hit_addr, w_fill_addr;
  logic                w_rd_hit, w_wr_hit, w_last_beat, w_beat_done, w_fill_en;

  assign w_off       = off_of(addr);
  assign w_idx       = idx_of(addr);
  assign w_tag       = addr[31 -: TAG_BITS];
  assign w_fill_off  = off_of(r_addr);
  assign w_fill_idx  = idx_of(r_addr);
  assign w_fill_tag  = r_addr[31 -: TAG_BITS];
  assign w_hit_addr  = {w_hit_way, w_idx, w_off};
  assign w_fill_addr = {r_victim, w_fill_idx, r_beat};

  assign w_rd_hit    = (r_state == IDLE) && read_request && !write_request && w_hit;
  assign w_wr_hit    = (r_state == IDLE) && write_request && w_hit;
  assign w_beat_done = (r_state == FILL) && memory_response;
  assign w_last_beat = (r_beat == OFF_W'(LINE_WORDS - 1));
  assign w_fill_en   = w_beat_done && w_last_beat && !rst;

  dcache_tag_array #(
    .WAYS      (WAYS),
    .SET_DEPTH (2**IDX_W),
    .IDX_W     (IDX_W),
    .TAG_BITS  (TAG_BITS),
    .WAY_W     (WAY_W)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (w_idx),
    .lookup_tag (w_tag),
    .hit        (w_hit),
    .hit_way    (w_hit_way),
    .victim_way (w_victim_way),
    .fill_en    (w_fill_en),
    .fill_idx   (w_fill_idx),
    .fill_way   (r_victim),
    .fill_tag   (w_fill_tag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and bus/response outputs, decoded from the current state.
  always_comb begin
    w_next_state         = r_state;
    response             = 1'b0;
    memory_read_request  = 1'b0;
    memory_write_request = 1'b0;
    memory_addr          = '0;
    memory_write_data    = '0;
    memory_write_strobe  = '0;
    case (r_state)
      IDLE: begin
        if (write_request)     w_next_state = WRITE;
        else if (read_request) w_next_state = w_hit ? RESP : FILL;
      end
      FILL: begin
        memory_read_request = 1'b1;
        memory_addr         = (r_addr & C_LINE_MASK) | (word_t'(r_beat) << 2);
        if (memory_response) w_next_state = w_last_beat ? RESP : FILL_GAP;
      end
      FILL_GAP: w_next_state = FILL;
      WRITE: begin
        memory_write_request = 1'b1;
        memory_addr          = r_addr;
        memory_write_data    = r_wdata;
        memory_write_strobe  = r_wstrb;
        if (memory_response) w_next_state = RESP;
      end
      RESP: begin
        response     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture, fill beat counter and registered load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_victim    <= '0;
      r_beat      <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_request || read_request) begin
            r_addr   <= addr;
            r_wdata  <= write_data;
            r_wstrb  <= write_strobe;
            r_victim <= w_victim_way;
            r_beat   <= '0;
          end
          if (w_rd_hit) r_read_data <= r_data[w_hit_addr];
        end
        FILL: begin
          if (memory_response) begin
            if (r_beat == w_fill_off) r_read_data <= memory_read_data;
            if (!w_last_beat)         r_beat      <= r_beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_data = r_read_data;

  // Data array: store hits merge in place, fill beats land in the victim way.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_wr_hit)
        r_data[w_hit_addr] <= merge_bytes(r_data[w_hit_addr], write_data, write_strobe);
      else if (w_beat_done)
        r_data[w_fill_addr] <= memory_read_data;
    end
  end

`ifdef DCACHE_STATS_EN
  // Read hit/miss counters, counted at the IDLE lookup decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((r_state == IDLE) && read_request && !write_request) begin
      if (w_hit) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_assoc
// Description : Self-checking bench for dcache_assoc (default parameters,
//               SETS=32). A bus responder with fixed latency answers bus
//               requests from a sparse memory model; a vector table drives
//               load/store transactions with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_assoc;

  localparam int LAT     = 2;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_request = 1'b0;
  logic        write_request = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        response;
  logic [31:0] read_data;
  logic        memory_read_request;
  logic        memory_write_request;
  logic        memory_response;
  logic [31:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_strobe;
  logic [31:0] memory_read_data;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  dcache_assoc dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_request         (read_request),
    .write_request        (write_request),
    .addr                 (addr),
    .write_data           (write_data),
    .write_strobe         (write_strobe),
    .response             (response),
    .read_data            (read_data),
    .memory_read_request  (memory_read_request),
    .memory_write_request (memory_write_request),
    .memory_response      (memory_response),
    .memory_addr          (memory_addr),
    .memory_write_data    (memory_write_data),
    .memory_write_strobe  (memory_write_strobe),
    .memory_read_data     (memory_read_data)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count            (hit_count),
    .miss_count           (miss_count)
`endif
  );

  // ---------------- memory model and bus responder ----------------
  logic [31:0] bmem [logic [31:0]];
  logic        auto_en   = 1'b1;
  logic        auto_resp = 1'b0;
  logic [31:0] auto_data = '0;
  logic        man_resp  = 1'b0;
  logic [31:0] man_data  = '0;
  int          lat_cnt   = 0;
  int          n_wr      = 0;
  int          gap_err   = 0;
  logic        prev_rd_resp = 1'b0;
  logic [31:0] rd_q [$];
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  assign memory_response  = auto_resp | man_resp;
  assign memory_read_data = auto_resp ? auto_data : man_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'h5A5A0000;
  endfunction

  always @(negedge clk) begin : responder
    logic [31:0] cur;
    if (prev_rd_resp && memory_read_request) gap_err++;
    prev_rd_resp = 1'b0;
    if (auto_en && !auto_resp && (memory_read_request || memory_write_request)) begin
      lat_cnt++;
      if (lat_cnt >= LAT) begin
        auto_resp = 1'b1;
        lat_cnt   = 0;
        if (memory_read_request) begin
          auto_data = mem_rd(memory_addr);
          rd_q.push_back(memory_addr);
          prev_rd_resp = 1'b1;
        end else begin
          cur = mem_rd(memory_addr);
          for (int b = 0; b < 4; b++)
            if (memory_write_strobe[b]) cur[b*8 +: 8] = memory_write_data[b*8 +: 8];
          bmem[memory_addr] = cur;
          last_waddr = memory_addr;
          last_wdata = memory_write_data;
          last_wstrb = memory_write_strobe;
          n_wr++;
        end
      end
    end else begin
      auto_resp = 1'b0;
      lat_cnt   = 0;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read_request = 1'b0; write_request = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction; lat = cycles from first sampling edge to response (0 = timeout).
  task automatic do_req(input logic is_wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output logic [31:0] rdata);
    lat   = 0;
    rdata = '0;
    @(negedge clk);
    addr = a; write_data = wd; write_strobe = st;
    read_request = !is_wr; write_request = is_wr;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (response) begin
        lat   = c;
        rdata = read_data;
        break;
      end
    end
    read_request = 1'b0; write_request = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, base_rd, base_wr, cnt;
    logic [31:0] rdata;
    logic stale_seen;

    // Miss: 4 beats * LAT + 3 gaps + 1 response = 12 cycles. Hit: 1. Write: LAT + 1.
    vecs[0]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h000000A0, 12, 4, 0};
    vecs[1]  = '{1'b0, 32'h108,  32'h0,        4'h0, 32'h000000A8,  1, 0, 0};
    vecs[2]  = '{1'b0, 32'h300,  32'h0,        4'h0, 32'h5A5A0300, 12, 4, 0};
    vecs[3]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h000000A0,  1, 0, 0};
    vecs[4]  = '{1'b0, 32'h300,  32'h0,        4'h0, 32'h5A5A0300,  1, 0, 0};
    vecs[5]  = '{1'b0, 32'h500,  32'h0,        4'h0, 32'h5A5A0500, 12, 4, 0};
    vecs[6]  = '{1'b0, 32'h300,  32'h0,        4'h0, 32'h5A5A0300,  1, 0, 0};
    vecs[7]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h000000A0, 12, 4, 0};
    vecs[8]  = '{1'b1, 32'h100,  32'h11223344, 4'hF, 32'h0,         3, 0, 1};
    vecs[9]  = '{1'b1, 32'h100,  32'h00005500, 4'h2, 32'h0,         3, 0, 1};
    vecs[10] = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h11225544,  1, 0, 0};
    vecs[11] = '{1'b1, 32'h2000, 32'hCAFEF00D, 4'hF, 32'h0,         3, 0, 1};
    vecs[12] = '{1'b0, 32'h2000, 32'h0,        4'h0, 32'hCAFEF00D, 12, 4, 0};
    vecs[13] = '{1'b0, 32'h2004, 32'h0,        4'h0, 32'h5A5A2004,  1, 0, 0};

    bmem[32'h100] = 32'h000000A0;
    bmem[32'h104] = 32'h000000A4;
    bmem[32'h108] = 32'h000000A8;
    bmem[32'h10C] = 32'h000000AC;

    // Reset state
    do_reset();
    check("rst_response",  {31'd0, response}, 32'd0);
    check("rst_mem_rd",    {31'd0, memory_read_request}, 32'd0);
    check("rst_mem_wr",    {31'd0, memory_write_request}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_mem_addr",  memory_addr, 32'd0);
    check("rst_mem_wdata", memory_write_data, 32'd0);
    check("rst_mem_wstrb", {28'd0, memory_write_strobe}, 32'd0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_count",  hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      base_rd = rd_q.size();
      base_wr = n_wr;
      do_req(vecs[i].is_wr, vecs[i].a, vecs[i].wd, vecs[i].st, lat, rdata);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_bus_reads", i), rd_q.size() - base_rd, vecs[i].exp_nrd);
      check($sformatf("v%0d_bus_writes", i), n_wr - base_wr, vecs[i].exp_nwr);
      if (!vecs[i].is_wr) begin
        check($sformatf("v%0d_read_data", i), rdata, vecs[i].exp_rd);
        if (vecs[i].exp_nrd == 4 && rd_q.size() - base_rd == 4)
          for (int k = 0; k < 4; k++)
            check($sformatf("v%0d_fill_addr%0d", i, k), rd_q[base_rd + k],
                  (vecs[i].a & 32'hFFFF_FFF0) + 32'(4 * k));
      end else if (n_wr - base_wr == 1) begin
        check($sformatf("v%0d_waddr", i), last_waddr, vecs[i].a);
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wd);
        check($sformatf("v%0d_wstrb", i), {28'd0, last_wstrb}, {28'd0, vecs[i].st});
      end
    end
    check("fill_gap_violations", gap_err, 0);

    // Reset in the middle of a line fill
    do_reset();
    base_rd = rd_q.size();
    @(negedge clk);
    addr = 32'h100; read_request = 1'b1;
    cnt = 0;
    while (rd_q.size() < base_rd + 2 && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    check("midfill_beats", rd_q.size() - base_rd, 2);
    @(negedge clk);
    rst = 1'b1; read_request = 1'b0;
    @(negedge clk);
    check("midfill_rst_rd_req", {31'd0, memory_read_request}, 32'd0);
    check("midfill_rst_read_data", read_data, 32'd0);
    rst = 1'b0;

    // Stale bus response in IDLE must be ignored
    auto_en = 1'b0; man_data = 32'hDEADBEEF; man_resp = 1'b1;
    @(negedge clk);
    man_resp = 1'b0;
    stale_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (response || memory_read_request || memory_write_request) stale_seen = 1'b1;
    end
    check("stale_resp_ignored", {31'd0, stale_seen}, 32'd0);
    auto_en = 1'b1;

    base_rd = rd_q.size();
    do_req(1'b0, 32'h100, 32'h0, 4'h0, lat, rdata);
    check("post_rst_latency", lat, 12);
    check("post_rst_bus_reads", rd_q.size() - base_rd, 4);
    check("post_rst_read_data", rdata, 32'h11225544);

`ifdef DCACHE_STATS_EN
    // 3 read misses, 5 read hits, 2 writes
    do_reset();
    begin
      logic [31:0] sa [10];
      logic        sw [10];
      sa = '{32'h100, 32'h104, 32'h108, 32'h300, 32'h304,
             32'h500, 32'h504, 32'h508, 32'h500, 32'h2000};
      sw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 10; i++) do_req(sw[i], sa[i], 32'h0, 4'h1, lat, rdata);
    end
    check("stats_miss_count", miss_count, 32'd3);
    check("stats_hit_count",  hit_count, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
